hazard_scoreboard_ctrl: RTL
===========================

// Module: hazard_scoreboard_ctrl
// PURPOSE
//  Scoreboard-based hazard and pipeline-sequencing controller for the instruction decode stage.
//  - Tracks outstanding register-file writes per architectural register.
//  - Stalls IF/ID on RAW or scoreboard-saturation hazards.
//  - Flushes IF/ID on a taken branch.
//  - Freezes the pipe on finish.
//  - Sits beside the decode stage: reads rs1/rs2/rd from decode, and writeback info from the WB stage.
// PARAMETERS
//  CNT_W         2  width of per-register pending-write counter (max in flight = 2**CNT_W-1)
//  FLUSH_CYCLES  1  cycles flush_if/flush_id held after a taken branch (>=1)
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   asynchronous, active-high reset
//  id_valid        in   1   decode holds a valid instruction
//  id_rs1          in   5   decode source register 1
//  id_rs2          in   5   decode source register 2
//  id_uses_rs1     in   1   instruction reads rs1
//  id_uses_rs2     in   1   instruction reads rs2
//  id_reg_write    in   1   instruction writes rd
//  id_rd           in   5   decode destination register
//  wb_reg_write    in   1   writeback commits a register write this cycle
//  wb_rd           in   5   writeback destination register
//  ex_is_branch    in   1   EX holds a branch
//  ex_branch_taken in   1   EX branch resolved taken (qualified by ex_is_branch)
//  finish          in   1   program end; freeze pipeline
//  issue           out  1   ID instruction advances to EX this cycle
//  stall_if        out  1   hold PC/IF register
//  stall_id        out  1   hold ID register
//  flush_if        out  1   squash IF instruction
//  flush_id        out  1   squash ID instruction (bubble into EX)
//  busy_map        out  32  bit r = pend_cnt[r]!=0
//  sb_err          out  1   sticky: WB release of register with pend_cnt==0
//  state           out  2   FSM state: RUN=0, STALL=1, FLUSH=2, HALT=3
// BEHAVIOUR
//  - Reset (async):
//    - all pend_cnt=0, state=RUN, flush counter=0, sb_err=0.
//    - Hence busy_map=0, stall_*=0, flush_*=0, issue=id_valid.
//  - hazard (comb):
//    - Set when id_valid and any of:
//      - id_uses_rs1 & rs1!=0 & pend_cnt[rs1]!=0;
//      - id_uses_rs2 & rs2!=0 & pend_cnt[rs2]!=0;
//      - id_reg_write & rd!=0 & pend_cnt[rd]==max.
//    - No bypass: WB of a register in cycle N clears its hazard from cycle N+1.
//  - take = ex_is_branch & ex_branch_taken.
//  - issue = id_valid & state==RUN & !hazard & !take & !finish.
//  - stall_if = stall_id = (hazard & state!=FLUSH) | state==HALT | finish.
//  - flush_if = flush_id = take | state==FLUSH.
//  - Scoreboard update (registered):
//    - +1 on pend_cnt[id_rd] when issue & id_reg_write & id_rd!=0.
//    - -1 on pend_cnt[wb_rd] when wb_reg_write & wb_rd!=0.
//    - Same register inc+dec in one cycle: net unchanged.
//    - Decrement at 0: counter stays 0, sb_err<=1.
//    - x0 never tracked.
//  - FSM (priority finish > take > hazard):
//    - RUN:   finish->HALT; take->FLUSH (load counter FLUSH_CYCLES-1); hazard->STALL; else RUN.
//    - STALL: finish->HALT; take->FLUSH; !hazard->RUN.
//    - FLUSH: finish->HALT.
//      - Otherwise counter==0 -> RUN, else decrement.
//      - A new take reloads the counter.
//    - HALT:  terminal until rst. Scoreboard still retires WB writes; no issue.
//  - Reset mid-operation discards all pending state, with no release of in-flight writes.
//  - Latency:
//    - Hazard -> stall: 0 cycles (comb).
//    - WB -> unstall: 1 cycle.
//    - Take -> flush: 0 cycles, held FLUSH_CYCLES+1 cycles total.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//  - Adds out ports stall_cnt[31:0] and flush_cnt[31:0].
//  - stall_cnt increments each cycle stall_id=1 and state!=HALT.
//  - flush_cnt increments per take event.
//  - Both are wrapping, reset to 0, and freeze in HALT.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. RAW stall:
//     - Stimulus: issue rd=5 (id_reg_write=1); next cycle id_rs1=5 valid.
//     - Response: stall_id=1, state=STALL until WB rd=5 in cycle N; issue=1 at N+1, busy_map[5]=0.
//  2. x0 ignored: issue rd=0, then rs1=0 -> no stall, busy_map=0.
//  3. Taken branch (FLUSH_CYCLES=1):
//     - Stimulus: ex_branch_taken=1 while id_valid.
//     - Response: issue=0, flush_if/flush_id=1 for 2 cycles, then RUN; pend_cnt unchanged.
//  4. Saturation (CNT_W=2):
//     - Issue rd=7 three times without WB -> 4th write to rd=7 stalls.
//     - One WB rd=7 -> issue next cycle.
//  5. Simultaneous issue rd=3 and WB rd=3 with pend_cnt=1 -> pend_cnt stays 1; stray WB rd=9 at 0 -> sb_err=1 sticky.
//  6. finish during STALL -> HALT, stall_*=1, issue=0 forever.
//     - rst pulse mid-HALT -> state=RUN, busy_map=0.
//     - Repeat with HAZARD_PERF_CNT_EN defined: check stall_cnt/flush_cnt.

Source files
------------

// File: rtl/hazard_scoreboard_ctrl_if.sv
// Decode/writeback/branch signals and controller outputs for hazard_scoreboard_ctrl.
// HAZARD_PERF_CNT_EN adds the stall_cnt/flush_cnt performance counter outputs.
interface hazard_scoreboard_ctrl_if;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        id_reg_write;
  logic [4:0]  id_rd;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic        ex_is_branch;
  logic        ex_branch_taken;
  logic        finish;
  logic        issue;
  logic        stall_if;
  logic        stall_id;
  logic        flush_if;
  logic        flush_id;
  logic [31:0] busy_map;
  logic        sb_err;
  logic [1:0]  state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_reg_write, id_rd,
           wb_reg_write, wb_rd, ex_is_branch, ex_branch_taken, finish,
    input  issue, stall_if, stall_id, flush_if, flush_id, busy_map, sb_err, state
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_reg_write, id_rd,
           wb_reg_write, wb_rd, ex_is_branch, ex_branch_taken, finish,
    output issue, stall_if, stall_id, flush_if, flush_id, busy_map, sb_err, state
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/hazard_scoreboard_ctrl.sv
// Decode-stage scoreboard: RAW/saturation stalls, taken-branch flush, halt on finish.
// Optional macro HAZARD_PERF_CNT_EN adds wrapping stall/flush performance counters.
module hazard_scoreboard_ctrl #(
  parameter int CNT_W        = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input logic                     clk,
  input logic                     rst,
  hazard_scoreboard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2, HALT = 2'd3} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam int               FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [FC_W-1:0]  fc_q, fc_d;
  logic [CNT_W-1:0] pend_q [32];
  logic [CNT_W-1:0] pend_d [32];
  logic             sb_err_q, sb_err_d;
  logic [31:0]      inc_v, dec_v, busy;
  logic             hazard, hazard_after, take, issue, stall;

  assign hazard = bus.id_valid & (
      (bus.id_uses_rs1  & (bus.id_rs1 != 5'd0) & (pend_q[bus.id_rs1] != '0)) |
      (bus.id_uses_rs2  & (bus.id_rs2 != 5'd0) & (pend_q[bus.id_rs2] != '0)) |
      (bus.id_reg_write & (bus.id_rd  != 5'd0) & (pend_q[bus.id_rd] == CNT_MAX)));

  // Same check against next cycle's scoreboard: lets STALL return to RUN so the
  // held instruction issues in the cycle right after its releasing writeback.
  assign hazard_after = bus.id_valid & (
      (bus.id_uses_rs1  & (bus.id_rs1 != 5'd0) & (pend_d[bus.id_rs1] != '0)) |
      (bus.id_uses_rs2  & (bus.id_rs2 != 5'd0) & (pend_d[bus.id_rs2] != '0)) |
      (bus.id_reg_write & (bus.id_rd  != 5'd0) & (pend_d[bus.id_rd] == CNT_MAX)));

  assign take  = bus.ex_is_branch & bus.ex_branch_taken;
  assign issue = bus.id_valid & (state_q == RUN) & ~hazard & ~take & ~bus.finish;
  assign stall = (hazard & (state_q != FLUSH)) | (state_q == HALT) | bus.finish;

  assign inc_v = (issue & bus.id_reg_write & (bus.id_rd != 5'd0)) ? (32'd1 << bus.id_rd) : 32'd0;
  assign dec_v = (bus.wb_reg_write & (bus.wb_rd != 5'd0))         ? (32'd1 << bus.wb_rd) : 32'd0;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pend_d   = pend_q;
    sb_err_d = sb_err_q;
    for (int r = 1; r < 32; r++) begin
      if (dec_v[r] && (pend_q[r] == '0)) begin
        sb_err_d = 1'b1;
      end else if (inc_v[r] && !dec_v[r]) begin
        pend_d[r] = pend_q[r] + CNT_W'(1);
      end else if (dec_v[r] && !inc_v[r]) begin
        pend_d[r] = pend_q[r] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    unique case (state_q)
      RUN: begin
        if (bus.finish)  state_d = HALT;
        else if (take)   begin state_d = FLUSH; fc_d = FC_LOAD; end
        else if (hazard) state_d = STALL;
      end
      STALL: begin
        if (bus.finish)         state_d = HALT;
        else if (take)          begin state_d = FLUSH; fc_d = FC_LOAD; end
        else if (!hazard_after) state_d = RUN;
      end
      FLUSH: begin
        if (bus.finish)         state_d = HALT;
        else if (take)          fc_d = FC_LOAD;
        else if (fc_q == '0)    state_d = RUN;
        else                    fc_d = fc_q - FC_W'(1);
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // NOTE: the scoreboard array is reset explicitly; stale pending counts after reset
  // would stall forever, so it cannot be left to power-up contents like a RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      fc_q     <= '0;
      sb_err_q <= 1'b0;
      for (int r = 0; r < 32; r++) pend_q[r] <= '0;
    end else begin
      state_q  <= state_d;
      fc_q     <= fc_d;
      sb_err_q <= sb_err_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < 32; r++) busy[r] = (pend_q[r] != '0);
  end

  assign bus.issue    = issue;
  assign bus.stall_if = stall;
  assign bus.stall_id = stall;
  assign bus.flush_if = take | (state_q == FLUSH);
  assign bus.flush_id = take | (state_q == FLUSH);
  assign bus.busy_map = busy;
  assign bus.sb_err   = sb_err_q;
  assign bus.state    = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (state_q != HALT) begin
      if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (take)  flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`endif
endmodule
